turbo_encoder: RTL and testbench

Rate-1/3 parallel-concatenated turbo encoder. It is the transmit-side counterpart of the siso decoder and uses the same 4-state recursive systematic trellis.
- Buffers one block of information bits.
- Drives two RSC encoders: one fed in natural order, one through an address-generator interleaver.
- Streams {systematic, parity1, parity2} symbols, followed by optional trellis-termination tail symbols.

---
 rtl/turbo_pkg.sv | 27 ++
 rtl/rsc_encoder.sv | 35 +++
 rtl/turbo_encoder.sv | 149 ++++++++++++++
 tb/tb_turbo_encoder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/turbo_pkg.sv
// rtl/turbo_pkg.sv - turbo encoder shared types, defaults and 4-state RSC trellis
package turbo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ENC,
        ST_TAIL
    } turbo_state_e;

    localparam int DEF_BLOCK_SIZE = 21;
    localparam int DEF_INTLV_STEP = 5;

    localparam int SYS  = 2;
    localparam int PAR1 = 1;
    localparam int PAR2 = 0;

    // State s = [s1 s0]; feedback a = u ^ s0 is both the parity and the new s1.
    function automatic logic [1:0] rsc_next(input logic [1:0] s, input logic u);
        return {u ^ s[0], s[1]};
    endfunction

    function automatic logic rsc_par(input logic [1:0] s, input logic u);
        return u ^ s[0];
    endfunction

endpackage

// File: rtl/rsc_encoder.sv
// rtl/rsc_encoder.sv - one recursive systematic constituent encoder with tail forcing
module rsc_encoder
    import turbo_pkg::*;
(
    input  logic       clk_p_i,
    input  logic       reset_n_i,
    input  logic       u,
    input  logic       adv,
    input  logic       term,
    input  logic       clr,
    output logic       parity,
    output logic       tail_u,
    output logic [1:0] state
);

    logic [1:0] state_q;
    logic       u_eff;

    // Feeding u = s0 zeroes the feedback, flushing the register in two steps.
    assign u_eff  = term ? state_q[0] : u;
    assign parity = rsc_par(state_q, u_eff);
    assign tail_u = state_q[0];
    assign state  = state_q;

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= 2'b00;
        end else if (clr) begin
            state_q <= 2'b00;
        end else if (adv) begin
            state_q <= rsc_next(state_q, u_eff);
        end
    end

endmodule

// File: rtl/turbo_encoder.sv
// rtl/turbo_encoder.sv - rate-1/3 turbo encoder top; TURBO_TERM_EN adds two trellis tail symbols
module turbo_encoder
    import turbo_pkg::*;
#(
    parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int INTLV_STEP = DEF_INTLV_STEP,
    parameter int CNT_W      = 5
) (
    input  logic       clk_p_i,
    input  logic       reset_n_i,
    input  logic       bit_i,
    input  logic       bit_valid_i,
    output logic       bit_ready_o,
    output logic [2:0] data_o,
    output logic       data_valid_o,
    input  logic       data_ready_i,
    output logic       tail_o,
    output logic       last_o
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_SIZE - 1);
`ifdef TURBO_TERM_EN
    localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(BLOCK_SIZE + 1);
`endif

    turbo_state_e          state_q, state_d;
    logic                  run_q;
    logic [BLOCK_SIZE-1:0] bit_buf_q;
    logic [CNT_W-1:0]      wr_cnt_q, sym_cnt_q, rd_idx_q, rd_idx_next;
    logic [CNT_W:0]        rd_sum, rd_wrap;

    logic is_enc, is_tail, in_hs, out_hs, load_done, enc_last;
    logic u1, u2, par1, par2, tail_u1, tail_u2, rsc_clr;
    logic [1:0] rsc1_state, rsc2_state;
    logic unused_sig;

    assign is_enc    = (state_q == ST_ENC);
    assign is_tail   = (state_q == ST_TAIL);
    assign in_hs     = bit_valid_i & bit_ready_o;
    assign out_hs    = data_valid_o & data_ready_i;
    assign load_done = in_hs & (state_q == ST_LOAD) & (wr_cnt_q == LAST_IDX);
    assign enc_last  = is_enc & (sym_cnt_q == LAST_IDX);

    // run_q keeps bit_ready_o low while reset is held and for the first edge after.
    assign bit_ready_o  = run_q & ((state_q == ST_IDLE) | (state_q == ST_LOAD));
    assign data_valid_o = is_enc | is_tail;

`ifdef TURBO_TERM_EN
    assign tail_o = is_tail;
    assign last_o = is_tail & (sym_cnt_q == LAST_SYM);
`else
    assign tail_o = 1'b0;
    assign last_o = enc_last;
`endif

    assign u1 = bit_buf_q[sym_cnt_q];
    assign u2 = bit_buf_q[rd_idx_q];

    // Interleaver address pi(k+1) = pi(k) + P, folded once since both terms are < BLOCK_SIZE.
    assign rd_sum      = {1'b0, rd_idx_q} + (CNT_W+1)'(INTLV_STEP);
    assign rd_wrap     = (rd_sum >= (CNT_W+1)'(BLOCK_SIZE)) ? rd_sum - (CNT_W+1)'(BLOCK_SIZE) : rd_sum;
    assign rd_idx_next = rd_wrap[CNT_W-1:0];

    assign rsc_clr = out_hs & last_o;

    rsc_encoder u_rsc1 (
        .clk_p_i   (clk_p_i),
        .reset_n_i (reset_n_i),
        .u         (u1),
        .adv       (out_hs),
        .term      (is_tail),
        .clr       (rsc_clr),
        .parity    (par1),
        .tail_u    (tail_u1),
        .state     (rsc1_state)
    );

    rsc_encoder u_rsc2 (
        .clk_p_i   (clk_p_i),
        .reset_n_i (reset_n_i),
        .u         (u2),
        .adv       (out_hs),
        .term      (is_tail),
        .clr       (rsc_clr),
        .parity    (par2),
        .tail_u    (tail_u2),
        .state     (rsc2_state)
    );

    assign unused_sig = ^{tail_u2, rsc1_state, rsc2_state, rd_wrap[CNT_W]};

    always_comb begin
        data_o = 3'b000;
        if (is_enc) begin
            data_o[SYS]  = u1;
            data_o[PAR1] = par1;
            data_o[PAR2] = par2;
        end else if (is_tail) begin
            data_o[SYS]  = tail_u1;
            data_o[PAR1] = par1;
            data_o[PAR2] = par2;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_hs) state_d = ST_LOAD;
            ST_LOAD: if (load_done) state_d = ST_ENC;
            ST_ENC: begin
                if (out_hs && enc_last) begin
`ifdef TURBO_TERM_EN
                    state_d = ST_TAIL;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_TAIL: if (out_hs && last_o) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_IDLE;
            run_q     <= 1'b0;
            bit_buf_q <= '0;
            wr_cnt_q  <= '0;
            sym_cnt_q <= '0;
            rd_idx_q  <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (in_hs) begin
                bit_buf_q[wr_cnt_q] <= bit_i;
                wr_cnt_q            <= (wr_cnt_q == LAST_IDX) ? '0 : wr_cnt_q + CNT_W'(1);
            end
            if (load_done) begin
                sym_cnt_q <= '0;
                rd_idx_q  <= '0;
            end else if (out_hs) begin
                sym_cnt_q <= last_o ? '0 : sym_cnt_q + CNT_W'(1);
                if (is_enc) rd_idx_q <= rd_idx_next;
            end
        end
    end

endmodule

// File: tb/tb_turbo_encoder.sv
// tb/tb_turbo_encoder.sv - directed self-checking bench for turbo_encoder
module tb_turbo_encoder;

    localparam int BS   = 21;
    localparam int STEP = 5;
`ifdef TURBO_TERM_EN
    localparam int NSYM = BS + 2;
`else
    localparam int NSYM = BS;
`endif

    logic       clk_p_i      = 1'b0;
    logic       reset_n_i    = 1'b1;
    logic       bit_i        = 1'b0;
    logic       bit_valid_i  = 1'b0;
    logic       data_ready_i = 1'b0;
    logic       bit_ready_o, data_valid_o, tail_o, last_o;
    logic [2:0] data_o;

    int checks      = 0;
    int errors      = 0;
    int cyc         = 0;
    int last_hs_cyc = 0;

    logic [4:0]    rx_sym  [0:NSYM-1];
    logic [4:0]    exp_sym [0:NSYM-1];
    logic [BS-1:0] blk_a, blk_b;
    logic [2:0]    d;

    turbo_encoder #(.BLOCK_SIZE(BS), .INTLV_STEP(STEP), .CNT_W(5)) dut (
        .clk_p_i      (clk_p_i),
        .reset_n_i    (reset_n_i),
        .bit_i        (bit_i),
        .bit_valid_i  (bit_valid_i),
        .bit_ready_o  (bit_ready_o),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .data_ready_i (data_ready_i),
        .tail_o       (tail_o),
        .last_o       (last_o)
    );

    always #5 clk_p_i = ~clk_p_i;
    always @(posedge clk_p_i) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk_p_i);
        #1;
    endtask

    task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        int t;
        t = 0;
        bit_i       = b;
        bit_valid_i = 1'b1;
        while (!bit_ready_o && t <= 200) begin
            step();
            t++;
        end
        check("send_timeout", 0, 32'(t <= 200), 32'd1);
        step();
        bit_valid_i = 1'b0;
    endtask

    task automatic send_block(input logic [BS-1:0] blk);
        for (int i = 0; i < BS; i++) send_bit(blk[i]);
    endtask

    task automatic recv(input int n, input int stall_pct);
        logic [5:0] held;
        int t;
        for (int k = 0; k < n; k++) begin
            t = 0;
            forever begin
                data_ready_i = ($urandom_range(99) >= stall_pct);
                if ((data_valid_o && data_ready_i) || t > 200) break;
                held = {data_valid_o, data_o, tail_o, last_o};
                step();
                t++;
                if (held[5]) check("stall_hold", k, 32'({data_valid_o, data_o, tail_o, last_o}), 32'(held));
            end
            check("recv_timeout", k, 32'(t <= 200), 32'd1);
            rx_sym[k] = {data_o, tail_o, last_o};
            step();
            last_hs_cyc  = cyc;
            data_ready_i = 1'b0;
        end
    endtask

    task automatic model(input logic [BS-1:0] blk);
        logic [1:0] s1 = 2'b00;
        logic [1:0] s2 = 2'b00;
        logic u, a1, a2;
        for (int k = 0; k < NSYM; k++) begin
            if (k < BS) begin
                u  = blk[k];
                a1 = blk[k] ^ s1[0];
                a2 = blk[(STEP * k) % BS] ^ s2[0];
            end else begin
                u  = s1[0];
                a1 = 1'b0;
                a2 = 1'b0;
            end
            exp_sym[k] = {u, a1, a2, k >= BS, k == NSYM - 1};
            s1 = {a1, s1[1]};
            s2 = {a2, s2[1]};
        end
    endtask

    task automatic compare(input string tag);
        for (int k = 0; k < NSYM; k++) check(tag, k, 32'(rx_sym[k]), 32'(exp_sym[k]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, 0, 32'({bit_ready_o, data_valid_o, data_o, tail_o, last_o}), 32'd0);
    endtask

    initial begin
        #1 reset_n_i = 1'b0;
        #1 check_reset_outputs("reset_out");
        repeat (2) @(posedge clk_p_i);
        #2 reset_n_i = 1'b1;
        step();
        check("ready_after_reset", 0, 32'(bit_ready_o), 32'd1);

        // all-zero block
        send_block('0);
        recv(NSYM, 0);
        for (int k = 0; k < NSYM; k++) exp_sym[k] = {3'b000, k >= BS, k == NSYM - 1};
        compare("zero_blk");
        check("zero_ready_next", 0, 32'({bit_ready_o, data_valid_o}), 32'b10);

        // impulse at bit 0: 111, then 000/011 alternating, tail 000 then 100
        blk_a = '0;
        blk_a[0] = 1'b1;
        send_block(blk_a);
        recv(NSYM, 0);
        for (int k = 0; k < NSYM; k++) begin
            if (k == 0)       d = 3'b111;
            else if (k < BS)  d = (k % 2 == 1) ? 3'b000 : 3'b011;
            else              d = (k == BS) ? 3'b000 : 3'b100;
            exp_sym[k] = {d, k >= BS, k == NSYM - 1};
        end
        compare("imp0_blk");

        // impulse at bit 5: par2 from symbol 1 (pi(1)=5), sys and par1 from symbol 5
        blk_a = '0;
        blk_a[5] = 1'b1;
        send_block(blk_a);
        recv(NSYM, 0);
        for (int k = 0; k < NSYM; k++) begin
            if (k < BS) d = {k == 5, (k % 2 == 1) && (k >= 5), k % 2 == 1};
            else        d = (k == BS) ? 3'b100 : 3'b000;
            exp_sym[k] = {d, k >= BS, k == NSYM - 1};
        end
        compare("imp5_blk");

        // random blocks with 50% output stalls
        for (int b = 0; b < 3; b++) begin
            blk_a = BS'($urandom());
            send_block(blk_a);
            recv(NSYM, 50);
            model(blk_a);
            compare("stall_blk");
        end

        // reset while loading bit 10
        blk_a = BS'($urandom());
        for (int i = 0; i < 10; i++) send_bit(blk_a[i]);
        bit_i       = blk_a[10];
        bit_valid_i = 1'b1;
        reset_n_i   = 1'b0;
        #1 check_reset_outputs("reset_at_load");
        step();
        step();
        bit_valid_i = 1'b0;
        reset_n_i   = 1'b1;
        step();
        blk_b = BS'($urandom());
        send_block(blk_b);
        recv(NSYM, 0);
        model(blk_b);
        compare("after_load_reset");

        // reset while emitting symbol 7
        send_block(BS'($urandom()));
        recv(7, 0);
        data_ready_i = 1'b1;
        reset_n_i    = 1'b0;
        #1 check_reset_outputs("reset_at_enc");
        data_ready_i = 1'b0;
        step();
        reset_n_i = 1'b1;
        step();
        blk_b = BS'($urandom());
        send_block(blk_b);
        recv(NSYM, 25);
        model(blk_b);
        compare("after_enc_reset");

        // back-to-back blocks with bit_valid_i held high through encoding
        blk_a = BS'($urandom());
        blk_b = BS'($urandom());
        send_block(blk_a);
        bit_i       = blk_b[0];
        bit_valid_i = 1'b1;
        recv(NSYM, 0);
        model(blk_a);
        compare("b2b_first");
        check("b2b_ready_after_last", 0, 32'(bit_ready_o), 32'd1);
        send_block(blk_b);
        check("b2b_first_valid", 0, 32'(data_valid_o), 32'd1);
        check("b2b_gap", 0, 32'(cyc - last_hs_cyc), 32'(BS));
        recv(NSYM, 0);
        model(blk_b);
        compare("b2b_second");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
